ni_packetizer: RTL and testbench

- Transmit side of the processor network interface. Accepts one message per handshake from the local processor, splits it into 8-bit flits (head, body..., tail), and drives them into the router's NI injection port.
- Flow control uses the router's noc_ready.
- Counterpart of the NI ejection path that consumes out_NI. Together they complete the processor-to-NoC interface.

---
 rtl/noc_pkg.sv | 9 +
 rtl/ni_flit_mux.sv | 39 +++
 rtl/ni_packetizer.sv | 80 ++++++++
 tb/tb_ni_packetizer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: flit encoding constants and NI packetizer FSM state shared by the NI transmit path.
package noc_pkg;
  localparam int FLIT_W = 8;
  localparam int CHUNK_W = 6;
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b10;
  typedef enum logic [1:0] {IDLE, HEAD, BODY} ni_state_e;
endpackage

// File: rtl/ni_flit_mux.sv
// ni_flit_mux: combinational formatter selecting the current flit from FSM state, body counter and latched fields.
// Ports: state, cnt select the flit; vc, src, dest, data are the latched packet fields; flit is the formatted flit (0 in IDLE).
// NI_CHECKSUM_EN: cnt == BODY_FLITS selects an XOR-of-chunks check flit, which becomes the tail.
module ni_flit_mux
  import noc_pkg::*;
#(
  parameter int BODY_FLITS = 4,
  parameter int NODE_W = 2
) (
  input  ni_state_e                     state,
  input  logic [3:0]                    cnt,
  input  logic                          vc,
  input  logic [NODE_W-1:0]             src,
  input  logic [NODE_W-1:0]             dest,
  input  logic [CHUNK_W*BODY_FLITS-1:0] data,
  output logic [FLIT_W-1:0]             flit
);
  logic [CHUNK_W-1:0] chunk;
  logic [FLIT_W-1:0] payload;
  always_comb begin
    chunk = '0;
    for (int i = 0; i < BODY_FLITS; i++)
      if (cnt == 4'(i)) chunk = data[CHUNK_W*i +: CHUNK_W];
  end
`ifdef NI_CHECKSUM_EN
  logic [CHUNK_W-1:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < BODY_FLITS; i++)
      csum ^= data[CHUNK_W*i +: CHUNK_W];
  end
  assign payload = cnt == 4'(BODY_FLITS) ? {FLIT_TAIL, csum} : {FLIT_BODY, chunk};
`else
  assign payload = {cnt == 4'(BODY_FLITS - 1) ? FLIT_TAIL : FLIT_BODY, chunk};
`endif
  assign flit = state == IDLE ? '0
              : state == HEAD ? {FLIT_HEAD, vc, 1'b0, src[1:0], dest[1:0]}
              : payload;
endmodule

// File: rtl/ni_packetizer.sv
// ni_packetizer: NI transmit side; accepts one processor message per handshake and injects it as head/body/tail flits.
// Ports: clk, rst (sync, active-high); src_node static node address; proc_valid/proc_dest/proc_data/proc_ready
// message handshake; noc_ready router flow control; flit_out/flit_valid injected flit; vc_id packet VC tag;
// busy packet in flight; pkt_count completed packets (wraps).
// NI_CHECKSUM_EN: appends an XOR check flit as the tail, making every payload flit a body flit.
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int BODY_FLITS = 4,
  parameter int NODE_W = 2,
  localparam int PAYLOAD_W = 6 * BODY_FLITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NODE_W-1:0]    src_node,
  input  logic                 proc_valid,
  input  logic [NODE_W-1:0]    proc_dest,
  input  logic [PAYLOAD_W-1:0] proc_data,
  output logic                 proc_ready,
  input  logic                 noc_ready,
  output logic [7:0]           flit_out,
  output logic                 flit_valid,
  output logic                 vc_id,
  output logic                 busy,
  output logic [15:0]          pkt_count
);
`ifdef NI_CHECKSUM_EN
  localparam logic [3:0] LAST = 4'(BODY_FLITS);
`else
  localparam logic [3:0] LAST = 4'(BODY_FLITS - 1);
`endif
  ni_state_e state, state_nxt;
  logic [3:0] cnt;
  logic [NODE_W-1:0] dest_q;
  logic [PAYLOAD_W-1:0] data_q;
  logic done;
  assign proc_ready = state == IDLE;
  assign flit_valid = state != IDLE;
  assign busy = state != IDLE;
  assign done = state == BODY && noc_ready && cnt == LAST;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = proc_valid ? HEAD : IDLE;
      HEAD: state_nxt = noc_ready ? BODY : HEAD;
      BODY: state_nxt = done ? IDLE : BODY;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      vc_id <= 1'b0;
      pkt_count <= '0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      cnt <= state != BODY || done ? 4'd0 : noc_ready ? cnt + 4'd1 : cnt;
      if (proc_ready && proc_valid) begin
        dest_q <= proc_dest;
        data_q <= proc_data;
      end
      if (done) begin
        pkt_count <= pkt_count + 16'd1;
        vc_id <= ~vc_id;
      end
    end
  end
  ni_flit_mux #(.BODY_FLITS(BODY_FLITS), .NODE_W(NODE_W)) u_mux (
    .state(state),
    .cnt(cnt),
    .vc(vc_id),
    .src(src_node),
    .dest(dest_q),
    .data(data_q),
    .flit(flit_out)
  );
endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: randomized self-checking bench for ni_packetizer against a packet-level reference model.
module tb_ni_packetizer;
`ifdef NI_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] src = 2'b00;
  logic proc_valid = 1'b0;
  logic [1:0] proc_dest = '0;
  logic [23:0] proc_data = '0;
  logic proc_ready, noc_ready = 1'b0;
  logic [7:0] flit_out;
  logic flit_valid, vc_id, busy;
  logic [15:0] pkt_count;
  logic p1_valid = 1'b0;
  logic [5:0] p1_data = '0;
  logic p1_ready, p1_fv, p1_vc, p1_busy;
  logic [7:0] p1_flit;
  logic [15:0] p1_pkt;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  logic exp_vc = 1'b0;
  logic [15:0] exp_pkt = '0;
  always #5 clk = ~clk;
  ni_packetizer #(.BODY_FLITS(4), .NODE_W(2)) dut (
    .clk(clk), .rst(rst), .src_node(src), .proc_valid(proc_valid), .proc_dest(proc_dest),
    .proc_data(proc_data), .proc_ready(proc_ready), .noc_ready(noc_ready), .flit_out(flit_out),
    .flit_valid(flit_valid), .vc_id(vc_id), .busy(busy), .pkt_count(pkt_count)
  );
  ni_packetizer #(.BODY_FLITS(1), .NODE_W(2)) dut1 (
    .clk(clk), .rst(rst), .src_node(2'b11), .proc_valid(p1_valid), .proc_dest(2'b01),
    .proc_data(p1_data), .proc_ready(p1_ready), .noc_ready(1'b1), .flit_out(p1_flit),
    .flit_valid(p1_fv), .vc_id(p1_vc), .busy(p1_busy), .pkt_count(p1_pkt)
  );
  // Reference packet: head, then each 6-bit chunk LSB-first, the last flit typed tail.
  task automatic fill_exp(input int bf, input logic vc, input logic [1:0] s, input logic [1:0] d,
                          input logic [47:0] data);
    logic [5:0] ch, x;
    x = '0;
    exp_q.delete();
    exp_q.push_back({2'b01, vc, 1'b0, s, d});
    for (int i = 0; i < bf; i++) begin
      ch = 6'((data >> (6 * i)) & 48'h3F);
      x ^= ch;
      exp_q.push_back({(i == bf - 1 && !CSUM) ? 2'b10 : 2'b00, ch});
    end
    if (CSUM) exp_q.push_back({2'b10, x});
  endtask
  // Starts at a negedge with the DUT idle; returns at the negedge after the tail (or at abort_at).
  task automatic run_pkt(input logic [1:0] d, input logic [23:0] data, input logic [23:0] next_data,
                         input bit keep, input int stall_idx, input int stall_len, input bit rnd,
                         input int abort_at);
    int idx, cyc, stalled;
    n_tests++;
    if (proc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: proc_ready=%b want 1", proc_ready);
    end
    proc_valid = 1'b1;
    proc_dest = d;
    proc_data = data;
    fill_exp(4, exp_vc, src, d, {24'b0, data});
    @(negedge clk);
    proc_valid = keep;
    proc_data = next_data;
    idx = 0;
    cyc = 0;
    stalled = 0;
    while (idx < exp_q.size() && cyc < 300) begin
      if (idx == abort_at) return;
      n_tests++;
      if (flit_valid !== 1'b1 || flit_out !== exp_q[idx] || vc_id !== exp_vc || busy !== 1'b1 || proc_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL flit[%0d]: got v=%b f=%h vc=%b busy=%b rdy=%b want v=1 f=%h vc=%b busy=1 rdy=0",
                 idx, flit_valid, flit_out, vc_id, busy, proc_ready, exp_q[idx], exp_vc);
      end
      if (idx == stall_idx && stalled < stall_len) begin
        noc_ready = 1'b0;
        stalled++;
      end else noc_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (noc_ready) idx++;
      cyc++;
    end
    if (idx < exp_q.size()) begin
      n_tests++;
      n_fail++;
      $display("FAIL pkt_timeout: sent %0d of %0d flits", idx, exp_q.size());
    end
    exp_pkt++;
    exp_vc = ~exp_vc;
    n_tests++;
    if (flit_valid !== 1'b0 || proc_ready !== 1'b1 || busy !== 1'b0 || pkt_count !== exp_pkt || vc_id !== exp_vc) begin
      n_fail++;
      $display("FAIL pkt_end: got v=%b rdy=%b busy=%b cnt=%0d vc=%b want v=0 rdy=1 busy=0 cnt=%0d vc=%b",
               flit_valid, proc_ready, busy, pkt_count, vc_id, exp_pkt, exp_vc);
    end
  endtask
  task automatic check_idle_after_reset(input string name);
    n_tests++;
    if (flit_valid !== 1'b0 || flit_out !== 8'h00 || proc_ready !== 1'b1 || busy !== 1'b0 ||
        vc_id !== 1'b0 || pkt_count !== 16'd0 || p1_fv !== 1'b0 || p1_pkt !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%b f=%h rdy=%b busy=%b vc=%b cnt=%0d v1=%b cnt1=%0d want v=0 f=00 rdy=1 busy=0 vc=0 cnt=0 v1=0 cnt1=0",
               name, flit_valid, flit_out, proc_ready, busy, vc_id, pkt_count, p1_fv, p1_pkt);
    end
    exp_vc = 1'b0;
    exp_pkt = '0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_after_reset("reset");
  endtask
  task automatic test_single_packet();
    run_pkt(2'b10, 24'hABCDEF, 24'h123456, 1'b0, -1, 0, 1'b0, -1);
  endtask
  task automatic test_backpressure();
    @(negedge clk);
    run_pkt(2'b10, 24'hABCDEF, 24'h654321, 1'b0, 2, 3, 1'b0, -1);
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    run_pkt(2'b01, 24'h5A5A5A, 24'hC3F00F, 1'b1, -1, 0, 1'b0, -1);
    run_pkt(2'b01, 24'hC3F00F, 24'h000000, 1'b0, -1, 0, 1'b0, -1);
  endtask
  task automatic test_random();
    logic [1:0] d;
    logic [23:0] data, nxt;
    bit keep;
    d = 2'($urandom);
    data = 24'($urandom);
    for (int k = 0; k < 16; k++) begin
      nxt = 24'($urandom);
      keep = (k != 15) && ($urandom_range(0, 1) == 1);
      run_pkt(d, data, nxt, keep, -1, 0, 1'b1, -1);
      data = keep ? nxt : 24'($urandom);
      if (!keep) d = 2'($urandom);
    end
  endtask
  task automatic test_reset_mid_body();
    @(negedge clk);
    run_pkt(2'b11, 24'h0F0F0F, 24'hFFFFFF, 1'b0, -1, 0, 1'b0, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_after_reset("reset_mid_body");
    run_pkt(2'b10, 24'h13579B, 24'h2468AC, 1'b0, -1, 0, 1'b1, -1);
  endtask
  task automatic test_single_flit();
    @(negedge clk);
    p1_valid = 1'b1;
    p1_data = 6'h15;
    fill_exp(1, 1'b0, 2'b11, 2'b01, 48'h15);
    @(negedge clk);
    p1_valid = 1'b0;
    p1_data = 6'h2A;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_tests++;
      if (p1_fv !== 1'b1 || p1_flit !== exp_q[k] || p1_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bf1_flit[%0d]: got v=%b f=%h busy=%b want v=1 f=%h busy=1", k, p1_fv, p1_flit, p1_busy, exp_q[k]);
      end
      @(negedge clk);
    end
    n_tests++;
    if (p1_fv !== 1'b0 || p1_ready !== 1'b1 || p1_pkt !== 16'd1 || p1_vc !== 1'b1) begin
      n_fail++;
      $display("FAIL bf1_end: got v=%b rdy=%b cnt=%0d vc=%b want v=0 rdy=1 cnt=1 vc=1", p1_fv, p1_ready, p1_pkt, p1_vc);
    end
  endtask
  initial begin
    test_reset();
    test_single_packet();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_body();
    test_single_flit();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
